dio_input_conditioner: RTL

//  Front-end stage for the MCC DIO path: takes raw DIO input pins (pins 9-16, InputA[15:8]),

---
 rtl/dio_input_conditioner.sv | 112 +++++++++++
 1 files changed

// File: rtl/dio_input_conditioner.sv
// DIO input conditioner: per-pin synchroniser, debounce, and registered rise/fall strobes.
// Optional rising-edge counter on a selected pin when DIO_EDGE_COUNT_EN is defined.
module dio_input_conditioner #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [WIDTH-1:0]   DioIn,
  input  logic [CNT_W-1:0]   DebounceCycles,
  output logic [WIDTH-1:0]   Clean,
  output logic [WIDTH-1:0]   Rise,
  output logic [WIDTH-1:0]   Fall,
  input  logic [2:0]         CountSel,
  input  logic               CountClear,
  output logic [15:0]        EdgeCount
);

  localparam int unsigned CNT_W1 = CNT_W + 1;
  localparam int unsigned EDGE_W = 16;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync_s;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_d;
  logic [WIDTH-1:0]                  clean_q;
  logic [WIDTH-1:0]                  clean_d;
  logic [WIDTH-1:0]                  rise_q;
  logic [WIDTH-1:0]                  rise_d;
  logic [WIDTH-1:0]                  fall_q;
  logic [WIDTH-1:0]                  fall_d;
  logic [CNT_W-1:0]                  neff;

  // Plain flop chain; nothing combinational between stages.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= DioIn;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // A zero threshold behaves like one: the pin follows the synchroniser directly.
  assign neff = (DebounceCycles == '0) ? CNT_W'(1) : DebounceCycles;

  // Per-pin debounce; compare is >= so a lowered threshold takes effect at once.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_s[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (({1'b0, cnt_q[i]} + CNT_W1'(1)) >= {1'b0, neff}) begin
        cnt_d[i]   = '0;
        clean_d[i] = sync_s[i];
        rise_d[i]  = sync_s[i];
        fall_d[i]  = ~sync_s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q   <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign Clean = clean_q;
  assign Rise  = rise_q;
  assign Fall  = fall_q;

`ifdef DIO_EDGE_COUNT_EN
  logic [EDGE_W-1:0] edge_cnt_q;

  // Saturating count of the selected pin's rise strobe; clear wins over increment.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      edge_cnt_q <= '0;
    end else if (CountClear) begin
      edge_cnt_q <= '0;
    end else if (rise_q[CountSel] && (edge_cnt_q != '1)) begin
      edge_cnt_q <= edge_cnt_q + EDGE_W'(1);
    end
  end

  assign EdgeCount = edge_cnt_q;
`else
  logic count_unused;

  assign count_unused = ^{CountSel, CountClear};
  assign EdgeCount    = EDGE_W'(0);
`endif

endmodule
